dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the pipeline MEM stage (core) and an auxiliary requester (program loader / debug DMA).
- Sits between the EX/MEM pipeline register outputs and the datamemory instance.
- Core has fixed priority. Aux is protected from starvation by a wait counter that forces a bounded aux burst.
- Drives a stall to the pipeline whenever the core is denied the port.

Parameters:
DATA_W, 32, data width
DM_ADDRESS, 9, data-memory address width
STARVE_LIM, 8, consecutive denied aux-request cycles before aux is forced in (>=1)
AUX_BURST, 2, max consecutive aux beats per forced window (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
core_rd  in  1  core load request (C.MemRead)
core_wr  in  1  core store request (C.MemWrite)
core_addr  in  DM_ADDRESS  core address
core_wdata  in  DATA_W  core store data
core_funct3  in  3  core access size/sign
core_rdata  out  DATA_W  core load data, same cycle
core_stall  out  1  core denied this cycle; pipeline must hold MEM and earlier stages
aux_req  in  1  aux request valid
aux_we  in  1  aux write (1) / read (0)
aux_addr  in  DM_ADDRESS  aux address
aux_wdata  in  DATA_W  aux write data
aux_funct3  in  3  aux access size/sign
aux_gnt  out  1  aux beat accepted this cycle
aux_rvalid  out  1  aux read data valid, one cycle after a granted read
aux_rdata  out  DATA_W  registered aux read data
mem_rd  out  1  to datamemory MemRead
mem_wr  out  1  to datamemory MemWrite
mem_addr  out  DM_ADDRESS  to datamemory address
mem_wdata  out  DATA_W  to datamemory write data
mem_funct3  out  3  to datamemory funct3
mem_rdata  in  DATA_W  from datamemory; combinational read, valid same cycle

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset.
- Definition: core_act = core_rd | core_wr.
- core_rd & core_wr together: the write wins; mem_rd = 0 for that beat.
- Owner is combinational from state and requests. All other state is registered.
- FSM states: ARB_CORE, ARB_AUX. Reset state is ARB_CORE.
- ARB_CORE:
  - core_act: core owns the port; aux_gnt = 0.
  - If aux_req is also high, wait_cnt increments (saturates at STARVE_LIM). When wait_cnt == STARVE_LIM-1 and the increment occurs, next state is ARB_AUX and burst_cnt is cleared.
  - !core_act & aux_req: aux owns the port, aux_gnt = 1, wait_cnt cleared.
  - Neither requesting: mem_rd = mem_wr = 0; wait_cnt cleared if !aux_req.
- ARB_AUX:
  - aux_req: aux owns the port, aux_gnt = 1, core_stall = core_act, burst_cnt increments.
  - When burst_cnt == AUX_BURST-1 at a grant, or aux_req is low, next state is ARB_CORE and wait_cnt is cleared.
  - aux_req low in ARB_AUX: core serviced that same cycle by the ARB_CORE rules, no stall.
- core_stall = core_act & !core-owns. It is never asserted when core_act = 0.
- Memory mux:
  - mem_* mirror the owner's signals. With no owner, mem_rd = mem_wr = 0; addr/wdata/funct3 are don't-care (drive core's).
- Read data:
  - core_rdata = mem_rdata (pass-through, zero latency).
  - aux_rdata/aux_rvalid are registered: aux_rvalid = 1 exactly one cycle after a granted aux read, with aux_rdata = mem_rdata captured at the grant edge.
  - A granted aux write produces no rvalid. aux_rdata holds its value otherwise.
- Reset:
  - While reset is high, all combinational outputs are forced 0 (aux_gnt, core_stall, mem_rd, mem_wr).
  - On the clock edge: state = ARB_CORE, wait_cnt = 0, burst_cnt = 0, aux_rvalid = 0, aux_rdata = 0.
  - Reset mid-burst discards any pending rvalid.
- Counter widths: wait_cnt is $clog2(STARVE_LIM+1) bits and burst_cnt is $clog2(AUX_BURST+1) bits. No wrap; both saturate.

Decomposition:
- Pipe_Buf_Reg_PKG gains the arb_state_t enum (ARB_CORE, ARB_AUX) and a dm_req_t struct (rd, wr, addr, wdata, funct3) used for both requesters and the memory side.
- One natural sub-module: arb_sat_counter (parameterized saturating counter with inc/clr), instantiated for both wait_cnt and burst_cnt.

Test Plan:
- Reset held 2 cycles with aux_req = core_rd = 1 -> aux_gnt = core_stall = mem_rd = 0. After release, core is granted first and aux_rvalid = 0.
- Core idle, aux read addr 0x010 with memory word 0xDEADBEEF -> aux_gnt = 1 in cycle 0; aux_rvalid = 1 and aux_rdata = 0xDEADBEEF in cycle 1; no core_stall.
- Core store addr 0x004 data 0x12345678 with aux idle -> mem_wr = 1, mem_addr = 0x004, mem_wdata = 0x12345678, core_stall = 0; core_rdata tracks mem_rdata in the same cycle.
- core_rd and aux_req held high continuously, STARVE_LIM = 8, AUX_BURST = 2 -> core granted cycles 0-7; aux granted cycles 8-9 with core_stall = 1; core granted again from cycle 10; pattern repeats every 10 cycles.
- Forced window entered but aux_req drops in its first ARB_AUX cycle -> state returns to ARB_CORE, core serviced that cycle with core_stall = 0, wait_cnt = 0.
- core_rd and core_wr both high, addr 0x020 -> mem_wr = 1, mem_rd = 0. Reset asserted in the cycle after an aux read grant -> aux_rvalid stays 0.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: arbitration state and the memory request bundle.
// dm_req_t carries the package widths; top-level width overrides must match them.
package dmem_arbiter_pkg;

    localparam int DM_DATA_W = 32;
    localparam int DM_ADDR_W = 9;

    typedef enum logic {
        ARB_CORE = 1'b0,
        ARB_AUX  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 rd;
        logic                 wr;
        logic [DM_ADDR_W-1:0] addr;
        logic [DM_DATA_W-1:0] wdata;
        logic [2:0]           funct3;
    } dm_req_t;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Holds at MAX instead of wrapping.
module arb_sat_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the MEM stage (fixed priority) and an aux requester.
// Aux is forced in for a bounded burst after STARVE_LIM consecutive denied cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W     = DM_DATA_W,
    parameter int DM_ADDRESS = DM_ADDR_W,
    parameter int STARVE_LIM = 8,
    parameter int AUX_BURST  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_funct3,
    output logic [DATA_W-1:0]     core_rdata,
    output logic                  core_stall,
    input  logic                  aux_req,
    input  logic                  aux_we,
    input  logic [DM_ADDRESS-1:0] aux_addr,
    input  logic [DATA_W-1:0]     aux_wdata,
    input  logic [2:0]            aux_funct3,
    output logic                  aux_gnt,
    output logic                  aux_rvalid,
    output logic [DATA_W-1:0]     aux_rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rdata
);

    localparam int WAIT_W  = $clog2(STARVE_LIM + 1);
    localparam int BURST_W = $clog2(AUX_BURST + 1);

    arb_state_t        state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic               rvalid_q;

    logic    core_act, core_own, aux_own;
    logic    wait_inc, wait_clr, burst_inc, enter_aux, exit_aux;
    dm_req_t core_req, aux_req_s, sel_req;

    assign core_act = core_rd | core_wr;

    // A simultaneous load+store from the core is treated as a store.
    always_comb begin
        core_req.rd     = core_rd & ~core_wr;
        core_req.wr     = core_wr;
        core_req.addr   = core_addr;
        core_req.wdata  = core_wdata;
        core_req.funct3 = core_funct3;

        aux_req_s.rd     = ~aux_we;
        aux_req_s.wr     = aux_we;
        aux_req_s.addr   = aux_addr;
        aux_req_s.wdata  = aux_wdata;
        aux_req_s.funct3 = aux_funct3;
    end

    // Dropping aux_req inside the forced window hands the port straight back to the core.
    always_comb begin
        core_own = 1'b0;
        aux_own  = 1'b0;
        if (state == ARB_AUX && aux_req) begin
            aux_own = 1'b1;
        end else begin
            core_own = core_act;
            aux_own  = ~core_act & aux_req & (state == ARB_CORE);
        end
    end

    assign wait_inc  = (state == ARB_CORE) & core_act & aux_req;
    assign enter_aux = wait_inc & (wait_cnt == WAIT_W'(STARVE_LIM - 1));
    assign burst_inc = (state == ARB_AUX) & aux_req;
    assign exit_aux  = (state == ARB_AUX) &
                       (~aux_req | (burst_cnt == BURST_W'(AUX_BURST - 1)));
    assign wait_clr  = ((state == ARB_CORE) & (~aux_req | aux_own)) | exit_aux;

    arb_sat_counter #(.MAX(STARVE_LIM), .W(WAIT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .cnt   (wait_cnt)
    );

    arb_sat_counter #(.MAX(AUX_BURST), .W(BURST_W)) u_burst_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (burst_inc),
        .clr   (enter_aux),
        .cnt   (burst_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_CORE;
            rvalid_q  <= 1'b0;
            aux_rdata <= '0;
        end else begin
            case (state)
                ARB_CORE: if (enter_aux) state <= ARB_AUX;
                ARB_AUX:  if (exit_aux)  state <= ARB_CORE;
                default:  state <= ARB_CORE;
            endcase
            rvalid_q <= aux_gnt & ~aux_we;
            if (aux_gnt && !aux_we) begin
                aux_rdata <= mem_rdata;
            end
        end
    end

    assign sel_req = aux_own ? aux_req_s : core_req;

    assign mem_rd     = ~reset & (core_own | aux_own) & sel_req.rd;
    assign mem_wr     = ~reset & (core_own | aux_own) & sel_req.wr;
    assign mem_addr   = sel_req.addr;
    assign mem_wdata  = sel_req.wdata;
    assign mem_funct3 = sel_req.funct3;

    assign aux_gnt    = ~reset & aux_own;
    assign core_stall = ~reset & core_act & ~core_own;
    assign core_rdata = mem_rdata;
    // A reset landing right after a read grant suppresses the pending rvalid immediately.
    assign aux_rvalid = ~reset & rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_rd, core_wr;
    logic [8:0]  core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_funct3;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        aux_req, aux_we;
    logic [8:0]  aux_addr;
    logic [31:0] aux_wdata;
    logic [2:0]  aux_funct3;
    logic        aux_gnt, aux_rvalid;
    logic [31:0] aux_rdata;
    logic        mem_rd, mem_wr;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata;

    logic [31:0] mem_array [0:511];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem_array[mem_addr];
    always @(posedge clk) if (mem_wr) mem_array[mem_addr] <= mem_wdata;

    dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .STARVE_LIM(8), .AUX_BURST(2)) dut (
        .clk(clk), .reset(reset),
        .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_funct3(core_funct3),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_funct3(aux_funct3),
        .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
    );

    // Inputs change 1 time unit after the rising edge; checks happen mid-cycle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        core_rd = 0; core_wr = 0; core_addr = '0; core_wdata = '0; core_funct3 = 3'd2;
        aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0; aux_funct3 = 3'd2;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; aux_req = 1; core_rd = 1; core_addr = 9'h008;
        for (int c = 0; c < 2; c++) begin
            step(); settle();
            checks++;
            if (aux_gnt !== 1'b0) begin errors++; $display("FAIL reset_aux_gnt cyc%0d: got %b want 0", c, aux_gnt); end
            checks++;
            if (core_stall !== 1'b0) begin errors++; $display("FAIL reset_core_stall cyc%0d: got %b want 0", c, core_stall); end
            checks++;
            if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd cyc%0d: got %b want 0", c, mem_rd); end
        end
        step(); reset = 0; settle();
        checks++;
        if ({mem_rd, aux_gnt, core_stall, aux_rvalid} !== 4'b1000) begin
            errors++; $display("FAIL post_reset_grant: got rd/gnt/stall/rvalid=%b want 1000",
                               {mem_rd, aux_gnt, core_stall, aux_rvalid});
        end
        step(); idle_inputs(); step();
    endtask

    task automatic test_aux_read();
        mem_array[9'h010] = 32'hDEADBEEF;
        aux_req = 1; aux_we = 0; aux_addr = 9'h010; aux_funct3 = 3'd2;
        settle();
        checks++;
        if ({aux_gnt, mem_rd, core_stall} !== 3'b110) begin
            errors++; $display("FAIL aux_read_grant: got gnt/rd/stall=%b want 110", {aux_gnt, mem_rd, core_stall});
        end
        checks++;
        if (mem_addr !== 9'h010) begin errors++; $display("FAIL aux_read_addr: got %h want 010", mem_addr); end
        step(); aux_req = 0; settle();
        checks++;
        if (aux_rvalid !== 1'b1) begin errors++; $display("FAIL aux_rvalid: got %b want 1", aux_rvalid); end
        checks++;
        if (aux_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL aux_rdata: got %h want deadbeef", aux_rdata); end
        step(); settle();
        checks++;
        if (aux_rvalid !== 1'b0) begin errors++; $display("FAIL aux_rvalid_drop: got %b want 0", aux_rvalid); end
        step();
    endtask

    task automatic test_core_store();
        mem_array[9'h004] = 32'hA5A50000;
        core_wr = 1; core_addr = 9'h004; core_wdata = 32'h12345678; core_funct3 = 3'd2;
        settle();
        checks++;
        if ({mem_wr, mem_rd, core_stall} !== 3'b100) begin
            errors++; $display("FAIL store_ctrl: got wr/rd/stall=%b want 100", {mem_wr, mem_rd, core_stall});
        end
        checks++;
        if (mem_addr !== 9'h004 || mem_wdata !== 32'h12345678 || mem_funct3 !== 3'd2) begin
            errors++; $display("FAIL store_bus: got addr=%h data=%h f3=%0d want 004 12345678 2", mem_addr, mem_wdata, mem_funct3);
        end
        checks++;
        if (core_rdata !== 32'hA5A50000) begin errors++; $display("FAIL core_rdata_pre: got %h want a5a50000", core_rdata); end
        step(); core_wr = 0; core_rd = 1; settle();
        checks++;
        if (core_rdata !== 32'h12345678) begin errors++; $display("FAIL core_rdata_post: got %h want 12345678", core_rdata); end
        step(); idle_inputs(); step();
    endtask

    task automatic test_starvation();
        logic exp_aux;
        core_rd = 1; core_addr = 9'h008;
        aux_req = 1; aux_we = 0; aux_addr = 9'h030;
        for (int c = 0; c < 20; c++) begin
            exp_aux = ((c % 10) >= 8);
            settle();
            checks++;
            if (aux_gnt !== exp_aux || core_stall !== exp_aux) begin
                errors++; $display("FAIL starve cyc%0d: got gnt=%b stall=%b want %b", c, aux_gnt, core_stall, exp_aux);
            end
            checks++;
            if (mem_addr !== (exp_aux ? 9'h030 : 9'h008)) begin
                errors++; $display("FAIL starve_addr cyc%0d: got %h want %h", c, mem_addr, exp_aux ? 9'h030 : 9'h008);
            end
            step();
        end
        idle_inputs(); step();
    endtask

    task automatic test_aux_drop();
        core_rd = 1; core_addr = 9'h008;
        aux_req = 1; aux_we = 0; aux_addr = 9'h030;
        for (int c = 0; c < 8; c++) step();
        aux_req = 0; settle();
        checks++;
        if ({core_stall, aux_gnt, mem_rd} !== 3'b001 || mem_addr !== 9'h008) begin
            errors++; $display("FAIL aux_drop: got stall/gnt/rd=%b addr=%h want 001 008", {core_stall, aux_gnt, mem_rd}, mem_addr);
        end
        step(); aux_req = 1;
        // A cleared wait counter means the next forced window needs the full 8 denied cycles.
        for (int c = 0; c < 9; c++) begin
            settle();
            checks++;
            if (aux_gnt !== (c == 8)) begin
                errors++; $display("FAIL wait_restart cyc%0d: got gnt=%b want %b", c, aux_gnt, (c == 8));
            end
            step();
        end
        idle_inputs(); step(); step();
    endtask

    task automatic test_rw_conflict();
        core_rd = 1; core_wr = 1; core_addr = 9'h020; core_wdata = 32'hCAFEF00D;
        settle();
        checks++;
        if ({mem_wr, mem_rd} !== 2'b10 || mem_addr !== 9'h020) begin
            errors++; $display("FAIL rw_conflict: got wr/rd=%b addr=%h want 10 020", {mem_wr, mem_rd}, mem_addr);
        end
        step(); idle_inputs(); step();
    endtask

    task automatic test_reset_mid();
        aux_req = 1; aux_we = 0; aux_addr = 9'h010;
        settle();
        checks++;
        if (aux_gnt !== 1'b1) begin errors++; $display("FAIL reset_mid_grant: got %b want 1", aux_gnt); end
        step(); aux_req = 0; reset = 1; settle();
        checks++;
        if (aux_rvalid !== 1'b0) begin errors++; $display("FAIL reset_mid_rvalid: got %b want 0", aux_rvalid); end
        step(); reset = 0; settle();
        checks++;
        if (aux_rvalid !== 1'b0 || aux_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_mid_after: got rvalid=%b rdata=%h want 0 0", aux_rvalid, aux_rdata);
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem_array[i] = 32'h0;
        idle_inputs();
        reset = 1;
        test_reset();
        test_aux_read();
        test_core_store();
        test_starvation();
        test_aux_drop();
        test_rw_conflict();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
